wide_to_narrow_serializer: RTL and testbench
============================================

# wide_to_narrow_serializer

Transmit-side width converter. Accepts one `WIDE_W`-bit word per valid/ready handshake and emits it as `RATIO` consecutive `NARROW_W`-bit slices, least-significant slice first, on a second valid/ready interface. It is the sending counterpart of the narrow-to-wide packer used by the parameter-override benchmarks. Widths are set by parameter or `defparam` (for example, width 8 in, width 2 out).

## Interface
Parameters:
- `NARROW_W`, default 2: output slice width in bits.
- `RATIO`, default 4: slices per input word; must be ≥ 1.
- `CNT_W`, default 2: slice-counter width; must satisfy 2^`CNT_W` ≥ `RATIO`.
- `WIDE_W`: derived, `NARROW_W`*`RATIO` (8 by default); not overridden independently.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  `WIDE_W`  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `out_data`  out  `NARROW_W`  current slice.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the slice this cycle.
- `out_last`  out  1  current slice is slice `RATIO`-1 of its word.
- `words_sent`  out  8  count of completed words; wraps 255 → 0.

## Operation
- Internal state:
  - `shreg` [`WIDE_W`]: word being sent.
  - `cnt` [`CNT_W`]: index of the current slice.
  - `out_valid` register.
  - `words_sent` register.
- Two states, encoded by `out_valid`:
  - IDLE (`out_valid`=0)
  - SEND (`out_valid`=1)
- `out_data` = `shreg`[`NARROW_W`-1:0].
- `out_last` = `out_valid` & (`cnt` == `RATIO`-1).
- `in_ready` = ~`out_valid` | (`out_ready` & `out_last`). This is combinational from `out_ready`.
- Input handshake (`in_valid` & `in_ready`):
  - `shreg` ← `in_data`
  - `cnt` ← 0
  - `out_valid` ← 1
- Output handshake, not the last slice (`out_valid` & `out_ready` & ~`out_last`):
  - `shreg` ← `shreg` >> `NARROW_W`, zero-filled.
  - `cnt` ← `cnt`+1.
- Output handshake on the last slice:
  - `words_sent` increments, modulo 256.
  - If an input handshake happens in the same cycle, the load wins. The next word starts with no bubble.
  - Otherwise `out_valid` ← 0 and the block returns to IDLE.
- `RATIO`=1: every slice is last. The block acts as a one-word register slice with full throughput.
- With no handshake, all state holds. `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- `in_data` is sampled only on an input handshake. Changes at any other time are ignored.

## Timing
- Reset (synchronous, the `clk` edge with `reset`=1):
  - `out_valid`=0, `shreg`=0, `cnt`=0, `words_sent`=0.
  - Resulting outputs: `out_data`=0, `out_last`=0, `in_ready`=1.
- Reset overrides every handshake in the same cycle.
- A word partially sent when reset asserts is discarded, with no further slices and no count.
- Latency: input handshake at edge N; slice 0 is valid after edge N. With `out_ready` held at 1, slices appear on consecutive cycles, and slice `RATIO`-1 is valid in cycle N+`RATIO`-1 (cycles counted after edge N).
- Sustained throughput is one word per `RATIO` cycles when `in_valid` and `out_ready` are held high.
- `out_valid`, `out_data` and `out_last` are register-driven, with no combinational path from the inputs.
- `in_ready` depends combinationally on `out_ready`. Upstream must not make `in_valid` depend on `in_ready`.
- Once `out_valid` is asserted, it does not drop until the last slice is accepted.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, then release with `in_valid`=0.
  - Required: `out_valid`=0, `in_ready`=1, `words_sent`=0, `out_data`=0 on every cycle.
- Single word, defaults, `out_ready`=1: `in_data`=8'hB4.
  - Required: `out_data` = 2'b00, 2'b01, 2'b11, 2'b10 on 4 consecutive cycles.
  - `out_last` high only on the 4th; `in_ready`=0 on slices 1–3; `words_sent`=1 afterwards.
- Back-to-back words: `in_valid` held with 8'hB4 then 8'h1E; `out_ready`=1.
  - Required: 8 consecutive valid slices 00,01,11,10,10,11,01,00 with no idle cycle.
  - `in_ready`=1 on the cycle of the first word's last slice; `words_sent`=2.
- Backpressure: send 8'hC3; hold `out_ready`=0 for 3 cycles while slice 1 (2'b00) is presented.
  - Required: `out_data`=2'b00 and `out_valid`=1 held stable; `cnt` unchanged.
  - Sequence completes as 11,00,00,11 after release.
- Reset mid-word: assert `reset` while slice 2 of 8'hFF is valid.
  - Required: next cycle `out_valid`=0 and `words_sent` unchanged from its reset value of 0.
  - The next word 8'h01 serializes from slice 0 (01,00,00,00).
- Wrap and `RATIO`=1 (via `defparam`: `RATIO`=1, `NARROW_W`=8, `CNT_W`=1): send 256 words continuously with `out_ready`=1.
  - Required: each word appears one cycle after its handshake, with `out_last`=1 on every slice.
  - `in_ready` stays 1 throughout; `words_sent` returns to 0.

Source files
------------

// File: rtl/wide_to_narrow_serializer.sv
// Splits one WIDE_W word into RATIO NARROW_W slices, least-significant slice first.
// Latency: slice 0 is valid the cycle after the input handshake; one slice per cycle after that.
// Backpressure: out_ready=0 freezes the current slice; in_ready opens only when idle or when the last slice is leaving.
module wide_to_narrow_serializer #(
    parameter  int NARROW_W = 2,
    parameter  int RATIO    = 4,
    parameter  int CNT_W    = 2,
    localparam int WIDE_W   = NARROW_W * RATIO
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDE_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NARROW_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [7:0]          words_sent
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WIDE_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          words_q, words_d;
    logic                in_hs;
    logic                out_hs;

    assign out_valid  = (state_q == SEND);
    assign out_data   = shreg_q[NARROW_W-1:0];
    assign out_last   = out_valid && (cnt_q == CNT_W'(RATIO - 1));
    assign in_ready   = !out_valid || (out_ready && out_last);
    assign words_sent = words_q;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        if (out_hs && !out_last) begin
            shreg_d = shreg_q >> NARROW_W;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (out_hs && out_last) begin
            words_d = words_q + 8'd1;
            state_d = IDLE;
        end
        // A load in the same cycle as the last slice overrides the return to IDLE, so words chain with no bubble.
        if (in_hs) begin
            shreg_d = in_data;
            cnt_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

endmodule

// File: tb/tb_wide_to_narrow_serializer.sv
// Bench for wide_to_narrow_serializer: default 8->2 instance plus a RATIO=1 8->8 instance.
module tb_wide_to_narrow_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic [7:0] words_sent;

    logic [7:0] d1_in_data = 8'h00;
    logic       d1_in_valid = 1'b0;
    logic       d1_in_ready;
    logic [7:0] d1_out_data;
    logic       d1_out_valid;
    logic       d1_out_ready = 1'b1;
    logic       d1_out_last;
    logic [7:0] d1_words_sent;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [2:0] sb_q[$];
    logic [7:0] exp_words = 8'd0;

    always #5 clk = ~clk;

    wide_to_narrow_serializer dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .words_sent(words_sent)
    );

    wide_to_narrow_serializer dut1 (
        .clk(clk), .reset(reset),
        .in_data(d1_in_data), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .out_data(d1_out_data), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_last(d1_out_last), .words_sent(d1_words_sent)
    );
    defparam dut1.RATIO = 1;
    defparam dut1.NARROW_W = 8;
    defparam dut1.CNT_W = 1;

    // Scoreboard: slices {last, data} are queued at the input handshake and retired at the output handshake.
    always @(negedge clk) begin
        logic [2:0] e;
        if (reset) begin
            sb_q.delete();
            exp_words = 8'd0;
        end else begin
            if (out_valid && out_ready) begin
                total_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected_slice got=%b_%b required=none", out_last, out_data);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_last, out_data} !== e)
                        $display("FAIL sb_slice got=%b_%b required=%b_%b", out_last, out_data, e[2], e[1:0]);
                    else
                        pass_cnt++;
                    if (e[2]) exp_words = exp_words + 8'd1;
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < 4; i++)
                    sb_q.push_back({(i == 3), in_data[2*i +: 2]});
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 5; c++) begin
            step();
            reset = (c < 1);
            in_valid = 1'b0;
            @(negedge clk);
            total_cnt += 5;
            if (out_valid !== 1'b0) $display("FAIL reset_out_valid c=%0d got=%b required=0", c, out_valid); else pass_cnt++;
            if (in_ready !== 1'b1) $display("FAIL reset_in_ready c=%0d got=%b required=1", c, in_ready); else pass_cnt++;
            if (words_sent !== 8'd0) $display("FAIL reset_words c=%0d got=%0d required=0", c, words_sent); else pass_cnt++;
            if (out_data !== 2'b00) $display("FAIL reset_out_data c=%0d got=%b required=00", c, out_data); else pass_cnt++;
            if (out_last !== 1'b0) $display("FAIL reset_out_last c=%0d got=%b required=0", c, out_last); else pass_cnt++;
        end
    endtask

    task automatic test_single;
        logic [1:0] tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        step();
        in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL single_idle_ready got=%b required=1", in_ready); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'b0; in_data = 8'h00;
            @(negedge clk);
            total_cnt += 4;
            if (out_valid !== 1'b1) $display("FAIL single_valid i=%0d got=%b required=1", i, out_valid); else pass_cnt++;
            if (out_data !== tbl[i]) $display("FAIL single_data i=%0d got=%b required=%b", i, out_data, tbl[i]); else pass_cnt++;
            if (out_last !== (i == 3)) $display("FAIL single_last i=%0d got=%b required=%b", i, out_last, (i == 3)); else pass_cnt++;
            if (in_ready !== (i == 3)) $display("FAIL single_in_ready i=%0d got=%b required=%b", i, in_ready, (i == 3)); else pass_cnt++;
        end
        step();
        @(negedge clk);
        total_cnt += 3;
        if (out_valid !== 1'b0) $display("FAIL single_idle got=%b required=0", out_valid); else pass_cnt++;
        if (words_sent !== 8'd1) $display("FAIL single_words got=%0d required=1", words_sent); else pass_cnt++;
        if (sb_q.size() != 0) $display("FAIL single_drain got=%0d required=0", sb_q.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [1:0] seq [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
        step();
        in_valid = 1'b1; in_data = 8'hB4; out_ready = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c <= 4) begin in_valid = 1'b1; in_data = 8'h1E; end
            else begin in_valid = 1'b0; in_data = 8'hFF; end
            @(negedge clk);
            total_cnt += 3;
            if (out_valid !== 1'b1) $display("FAIL b2b_valid c=%0d got=%b required=1", c, out_valid); else pass_cnt++;
            if (out_data !== seq[c-1]) $display("FAIL b2b_data c=%0d got=%b required=%b", c, out_data, seq[c-1]); else pass_cnt++;
            if (c <= 4 && in_ready !== (c == 4))
                $display("FAIL b2b_in_ready c=%0d got=%b required=%b", c, in_ready, (c == 4));
            else
                pass_cnt++;
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt += 3;
        if (out_valid !== 1'b0) $display("FAIL b2b_idle got=%b required=0", out_valid); else pass_cnt++;
        if (words_sent !== 8'd3 || words_sent !== exp_words)
            $display("FAIL b2b_words got=%0d required=3 model=%0d", words_sent, exp_words);
        else
            pass_cnt++;
        if (sb_q.size() != 0) $display("FAIL b2b_drain got=%0d required=0", sb_q.size()); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic [1:0] tail [3] = '{2'b00, 2'b00, 2'b11};
        step();
        in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b1;
        @(negedge clk);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_data !== 2'b11) $display("FAIL bp_slice0 got=%b required=11", out_data); else pass_cnt++;
        for (int c = 2; c <= 4; c++) begin
            step();
            out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
            @(negedge clk);
            total_cnt += 4;
            if (out_data !== 2'b00) $display("FAIL bp_hold_data c=%0d got=%b required=00", c, out_data); else pass_cnt++;
            if (out_valid !== 1'b1) $display("FAIL bp_hold_valid c=%0d got=%b required=1", c, out_valid); else pass_cnt++;
            if (dut.cnt_q !== 2'd1) $display("FAIL bp_hold_cnt c=%0d got=%0d required=1", c, dut.cnt_q); else pass_cnt++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got=%b required=0", c, in_ready); else pass_cnt++;
        end
        for (int c = 0; c < 3; c++) begin
            step();
            out_ready = 1'b1; in_valid = 1'b0;
            @(negedge clk);
            total_cnt += 2;
            if (out_data !== tail[c]) $display("FAIL bp_tail_data c=%0d got=%b required=%b", c, out_data, tail[c]); else pass_cnt++;
            if (out_last !== (c == 2)) $display("FAIL bp_tail_last c=%0d got=%b required=%b", c, out_last, (c == 2)); else pass_cnt++;
        end
        step();
        @(negedge clk);
        total_cnt += 2;
        if (out_valid !== 1'b0) $display("FAIL bp_idle got=%b required=0", out_valid); else pass_cnt++;
        if (words_sent !== 8'd4) $display("FAIL bp_words got=%0d required=4", words_sent); else pass_cnt++;
    endtask

    task automatic test_reset_mid_word;
        logic [1:0] tbl [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
        step();
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 2; c++) begin
            step();
            in_valid = 1'b0;
            @(negedge clk);
        end
        step();
        reset = 1'b1;
        @(negedge clk);
        total_cnt += 2;
        if (out_valid !== 1'b1) $display("FAIL rmid_slice2_valid got=%b required=1", out_valid); else pass_cnt++;
        if (out_data !== 2'b11) $display("FAIL rmid_slice2_data got=%b required=11", out_data); else pass_cnt++;
        step();
        reset = 1'b0;
        @(negedge clk);
        total_cnt += 2;
        if (out_valid !== 1'b0) $display("FAIL rmid_valid got=%b required=0", out_valid); else pass_cnt++;
        if (words_sent !== 8'd0) $display("FAIL rmid_words got=%0d required=0", words_sent); else pass_cnt++;
        step();
        in_valid = 1'b1; in_data = 8'h01;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (out_data !== tbl[i]) $display("FAIL rmid_next_data i=%0d got=%b required=%b", i, out_data, tbl[i]); else pass_cnt++;
        end
        step();
        @(negedge clk);
        total_cnt += 2;
        if (words_sent !== 8'd1) $display("FAIL rmid_next_words got=%0d required=1", words_sent); else pass_cnt++;
        if (sb_q.size() != 0) $display("FAIL rmid_drain got=%0d required=0", sb_q.size()); else pass_cnt++;
    endtask

    task automatic test_ratio1_wrap;
        logic [7:0] prev = 8'h00;
        d1_out_ready = 1'b1;
        for (int i = 0; i <= 257; i++) begin
            step();
            if (i < 256) begin d1_in_valid = 1'b1; d1_in_data = 8'(i * 73 + 11); end
            else begin d1_in_valid = 1'b0; d1_in_data = 8'hAA; end
            @(negedge clk);
            total_cnt++;
            if (d1_in_ready !== 1'b1) $display("FAIL r1_in_ready i=%0d got=%b required=1", i, d1_in_ready); else pass_cnt++;
            if (i >= 1 && i <= 256) begin
                total_cnt += 3;
                if (d1_out_valid !== 1'b1) $display("FAIL r1_valid i=%0d got=%b required=1", i, d1_out_valid); else pass_cnt++;
                if (d1_out_data !== prev) $display("FAIL r1_data i=%0d got=%h required=%h", i, d1_out_data, prev); else pass_cnt++;
                if (d1_out_last !== 1'b1) $display("FAIL r1_last i=%0d got=%b required=1", i, d1_out_last); else pass_cnt++;
            end
            if (i == 200) begin
                total_cnt++;
                if (d1_words_sent !== 8'd199) $display("FAIL r1_words_mid got=%0d required=199", d1_words_sent); else pass_cnt++;
            end
            if (i == 257) begin
                total_cnt += 2;
                if (d1_out_valid !== 1'b0) $display("FAIL r1_idle got=%b required=0", d1_out_valid); else pass_cnt++;
                if (d1_words_sent !== 8'd0) $display("FAIL r1_words_wrap got=%0d required=0", d1_words_sent); else pass_cnt++;
            end
            if (i < 256) prev = d1_in_data;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_ratio1_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
